conv_puncture: RTL and testbench

Rate-adaptation stage of the 802.11a transmitter, directly downstream of the rate-1/2 K=7 convolutional encoder. Consumes encoder output pairs {A,B}, deletes bits per the 802.11a puncturing pattern for coding rate 1/2, 2/3 or 3/4, and serialises surviving bits at one bit per clock toward the interleaver. Back-pressures the encoder with a ready signal so that no encoded bit is lost or duplicated.

---
 rtl/ofdm_tx_pkg.sv | 45 ++++
 rtl/punct_mask.sv | 31 +++
 rtl/conv_puncture.sv | 97 +++++++++
 tb/tb_conv_puncture.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_tx_pkg.sv
// Shared 802.11a transmit definitions: coding-rate codes, puncturing keep masks
// and pattern periods used by the puncturer and the receive-side depuncturer.
package ofdm_tx_pkg;

    typedef enum logic [1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_t;

    // Keep masks are {keep_a, keep_b}; A is always emitted before B.
    localparam logic [1:0] KEEP_1_2_P0 = 2'b11;
    localparam logic [1:0] KEEP_2_3_P0 = 2'b11;
    localparam logic [1:0] KEEP_2_3_P1 = 2'b10;
    localparam logic [1:0] KEEP_3_4_P0 = 2'b11;
    localparam logic [1:0] KEEP_3_4_P1 = 2'b10;
    localparam logic [1:0] KEEP_3_4_P2 = 2'b01;

    localparam logic [1:0] PERIOD_1_2 = 2'd1;
    localparam logic [1:0] PERIOD_2_3 = 2'd2;
    localparam logic [1:0] PERIOD_3_4 = 2'd3;

    function automatic logic [1:0] rate_period(input rate_t rate);
        logic [1:0] period;
        case (rate)
            RATE_2_3: period = PERIOD_2_3;
            RATE_3_4: period = PERIOD_3_4;
            default:  period = PERIOD_1_2;
        endcase
        return period;
    endfunction

    // The reserved code is treated as rate 1/2 so the burst still goes out.
    function automatic rate_t rate_normalise(input logic [1:0] code);
        rate_t rate;
        case (code)
            2'b01:   rate = RATE_2_3;
            2'b10:   rate = RATE_3_4;
            default: rate = RATE_1_2;
        endcase
        return rate;
    endfunction

endpackage

// File: rtl/punct_mask.sv
// Combinational puncturing pattern lookup: (rate, phase) -> which of A/B survive.
module punct_mask
    import ofdm_tx_pkg::*;
(
    input  rate_t       rate,
    input  logic [1:0]  phase,
    output logic        keep_a,
    output logic        keep_b
);

    logic [1:0] mask;

    // Out-of-range phases fall back to keeping both bits, never to dropping a pair.
    always_comb begin
        mask = KEEP_1_2_P0;
        case (rate)
            RATE_2_3: mask = (phase == 2'd1) ? KEEP_2_3_P1 : KEEP_2_3_P0;
            RATE_3_4: begin
                case (phase)
                    2'd1:    mask = KEEP_3_4_P1;
                    2'd2:    mask = KEEP_3_4_P2;
                    default: mask = KEEP_3_4_P0;
                endcase
            end
            default:  mask = KEEP_1_2_P0;
        endcase
    end

    assign {keep_a, keep_b} = mask;

endmodule

// File: rtl/conv_puncture.sv
// 802.11a puncturer: deletes encoder bits per rate pattern and serialises the
// survivors at one bit per clock, stalling the encoder while a second bit drains.
module conv_puncture
    import ofdm_tx_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rstn,
    input  logic [1:0]  rate_sel,
    input  logic        sym_start,
    input  logic [1:0]  data_in,
    input  logic        data_last_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic        data_out,
    output logic        data_valid_o,
    output logic        data_last_o,
    output logic        rate_err_o
);

    rate_t      rate_q;
    rate_t      pair_rate;
    logic [1:0] phase_q;
    logic [1:0] pair_phase;
    logic [1:0] phase_inc;
    logic [1:0] next_phase;
    logic [1:0] period;
    logic       hold_cnt;
    logic       hold_bit;
    logic       hold_last;
    logic       accept;
    logic       keep_a;
    logic       keep_b;
    logic       two_kept;
    logic       first_bit;

    assign data_ready_o = ~hold_cnt;
    assign accept       = data_valid_i & data_ready_o;

    // A pair flagged sym_start is punctured with the newly selected rate from phase 0.
    assign pair_rate  = sym_start ? rate_normalise(rate_sel) : rate_q;
    assign pair_phase = sym_start ? 2'd0 : phase_q;

    punct_mask u_punct_mask (
        .rate   (pair_rate),
        .phase  (pair_phase),
        .keep_a (keep_a),
        .keep_b (keep_b)
    );

    assign two_kept   = keep_a & keep_b;
    assign first_bit  = keep_a ? data_in[1] : data_in[0];
    assign period     = rate_period(pair_rate);
    assign phase_inc  = pair_phase + 2'd1;
    assign next_phase = (data_last_i || (phase_inc >= period)) ? 2'd0 : phase_inc;

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rate_q     <= RATE_1_2;
            phase_q    <= 2'd0;
            rate_err_o <= 1'b0;
        end else if (accept) begin
            rate_q  <= pair_rate;
            phase_q <= next_phase;
            if (sym_start && (rate_sel == RATE_RSVD)) begin
                rate_err_o <= 1'b1;
            end
        end
    end

    // Accept and drain are exclusive because ready is low whenever a bit is held.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            data_out     <= 1'b0;
            data_valid_o <= 1'b0;
            data_last_o  <= 1'b0;
            hold_cnt     <= 1'b0;
            hold_bit     <= 1'b0;
            hold_last    <= 1'b0;
        end else if (accept) begin
            data_out     <= first_bit;
            data_valid_o <= 1'b1;
            data_last_o  <= data_last_i & ~two_kept;
            hold_cnt     <= two_kept;
            hold_bit     <= data_in[0];
            hold_last    <= data_last_i & two_kept;
        end else if (hold_cnt) begin
            data_out     <= hold_bit;
            data_valid_o <= 1'b1;
            data_last_o  <= hold_last;
            hold_cnt     <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            data_last_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_puncture.sv
// Self-checking bench for conv_puncture: a queue-based model of the kept-bit
// stream is compared against the DUT every cycle, plus directed literal streams.
module tb_conv_puncture;

    logic       sys_clk = 1'b0;
    logic       sys_rstn;
    logic [1:0] rate_sel;
    logic       sym_start;
    logic [1:0] data_in;
    logic       data_last_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic       data_out;
    logic       data_valid_o;
    logic       data_last_o;
    logic       rate_err_o;

    int checks = 0;
    int errors = 0;

    int         m_period = 1;
    int         m_k = 0;
    logic       m_err = 1'b0;
    logic       exp_out = 1'b0;
    logic       exp_valid = 1'b0;
    logic       exp_last = 1'b0;
    logic [1:0] exp_q[$];
    logic [1:0] obs[$];

    conv_puncture dut (
        .sys_clk      (sys_clk),
        .sys_rstn     (sys_rstn),
        .rate_sel     (rate_sel),
        .sym_start    (sym_start),
        .data_in      (data_in),
        .data_last_i  (data_last_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .data_out     (data_out),
        .data_valid_o (data_valid_o),
        .data_last_o  (data_last_o),
        .rate_err_o   (rate_err_o)
    );

    always #5 sys_clk = ~sys_clk;

    // 802.11a puncturing matrices, one character per pair position in the period.
    function automatic bit keeps(input int per, input int ph, input bit is_b);
        string pa;
        string pb;
        case (per)
            3:       begin pa = "110"; pb = "101"; end
            2:       begin pa = "11";  pb = "10";  end
            default: begin pa = "1";   pb = "1";   end
        endcase
        return is_b ? (pb[ph] == "1") : (pa[ph] == "1");
    endfunction

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: accepted pairs push their kept bits; one bit leaves per cycle.
    initial begin
        forever begin
            @(posedge sys_clk or negedge sys_rstn);
            if (!sys_rstn) begin
                exp_q.delete();
                m_period  = 1;
                m_k       = 0;
                m_err     = 1'b0;
                exp_out   = 1'b0;
                exp_valid = 1'b0;
                exp_last  = 1'b0;
            end else begin
                if (data_valid_i === 1'b1 && exp_q.size() == 0) begin
                    int ph;
                    bit ka;
                    bit kb;
                    if (sym_start) begin
                        m_k      = 0;
                        m_period = (rate_sel == 2'b01) ? 2 : (rate_sel == 2'b10) ? 3 : 1;
                        if (rate_sel == 2'b11) m_err = 1'b1;
                    end
                    ph = m_k % m_period;
                    ka = keeps(m_period, ph, 1'b0);
                    kb = keeps(m_period, ph, 1'b1);
                    if (ka && kb) begin
                        exp_q.push_back({data_in[1], 1'b0});
                        exp_q.push_back({data_in[0], data_last_i});
                    end else if (ka) begin
                        exp_q.push_back({data_in[1], data_last_i});
                    end else begin
                        exp_q.push_back({data_in[0], data_last_i});
                    end
                    m_k = data_last_i ? 0 : m_k + 1;
                end
                if (exp_q.size() > 0) begin
                    logic [1:0] e;
                    e         = exp_q.pop_front();
                    exp_out   = e[1];
                    exp_valid = 1'b1;
                    exp_last  = e[0];
                end else begin
                    exp_valid = 1'b0;
                    exp_last  = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            checkOutput("ready", data_ready_o, exp_q.size() == 0);
            checkOutput("valid", data_valid_o, exp_valid);
            checkOutput("last", data_last_o, exp_last);
            checkOutput("out", data_out, exp_out);
            checkOutput("rate_err", rate_err_o, m_err);
            if (data_valid_o === 1'b1) obs.push_back({data_out, data_last_o});
        end
    end

    task automatic applyStimulus(input logic [1:0] pair, input logic sos, input logic last,
                                 input logic [1:0] rsel);
        int wait_cycles;
        wait_cycles = 0;
        @(negedge sys_clk);
        data_in      = pair;
        sym_start    = sos;
        data_last_i  = last;
        rate_sel     = rsel;
        data_valid_i = 1'b1;
        while (data_ready_o !== 1'b1 && wait_cycles < 20) begin
            @(negedge sys_clk);
            wait_cycles++;
        end
        if (data_ready_o !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: ready=%b, required 1 within 20 cycles", data_ready_o);
        end
        @(posedge sys_clk);
    endtask

    task automatic idleCycles(input int n);
        @(negedge sys_clk);
        data_valid_i = 1'b0;
        sym_start    = 1'b0;
        data_last_i  = 1'b0;
        repeat (n - 1) @(negedge sys_clk);
    endtask

    // Compares the captured DUT stream with a hand-computed bit list (MSB first).
    task automatic checkStream(input string name, input logic [15:0] bits, input int n,
                               input int last_idx);
        checks++;
        if (obs.size() != n) begin
            errors++;
            $display("[TB] FAIL %s_len: got %0d bits, expected %0d", name, obs.size(), n);
        end
        for (int i = 0; i < n && i < obs.size(); i++) begin
            checkOutput($sformatf("%s_bit%0d", name, i), obs[i][1], bits[n - 1 - i]);
            checkOutput($sformatf("%s_last%0d", name, i), obs[i][0], i == last_idx);
        end
        obs.delete();
    endtask

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion before 500000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [1:0] r;
        logic [1:0] rs;
        logic       sos;
        int         len;
        sys_rstn     = 1'b0;
        rate_sel     = 2'b00;
        sym_start    = 1'b0;
        data_in      = 2'b00;
        data_last_i  = 1'b0;
        data_valid_i = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("rst_out", data_out, 1'b0);
        checkOutput("rst_valid", data_valid_o, 1'b0);
        checkOutput("rst_last", data_last_o, 1'b0);
        checkOutput("rst_err", rate_err_o, 1'b0);
        checkOutput("rst_ready", data_ready_o, 1'b1);
        @(negedge sys_clk);
        sys_rstn = 1'b1;
        obs.delete();

        $display("[TB] rate 1/2 directed");
        applyStimulus(2'b10, 1'b1, 1'b0, 2'b00);
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b00);
        applyStimulus(2'b11, 1'b0, 1'b0, 2'b00);
        applyStimulus(2'b00, 1'b0, 1'b1, 2'b00);
        idleCycles(4);
        checkStream("r12", 16'b10011100, 8, 7);

        $display("[TB] rate 2/3 directed");
        applyStimulus(2'b11, 1'b1, 1'b0, 2'b01);
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b01);
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b01);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'b01);
        idleCycles(4);
        checkStream("r23", 16'b111011, 6, 5);

        $display("[TB] rate 3/4 directed");
        for (int i = 0; i < 6; i++) applyStimulus(2'b10, i == 0, i == 5, 2'b10);
        idleCycles(4);
        checkStream("r34", 16'b10101010, 8, 7);

        $display("[TB] rate 3/4 with input gap");
        applyStimulus(2'b10, 1'b1, 1'b0, 2'b10);
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b10);
        idleCycles(5);
        checkOutput("gap_valid", data_valid_o, 1'b0);
        checkOutput("gap_ready", data_ready_o, 1'b1);
        applyStimulus(2'b01, 1'b0, 1'b0, 2'b10);
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b10);
        applyStimulus(2'b10, 1'b0, 1'b0, 2'b10);
        applyStimulus(2'b10, 1'b0, 1'b1, 2'b10);
        idleCycles(4);
        checkStream("r34gap", 16'b10011010, 8, 7);

        $display("[TB] reserved rate code");
        applyStimulus(2'b10, 1'b1, 1'b0, 2'b11);
        applyStimulus(2'b01, 1'b0, 1'b1, 2'b11);
        idleCycles(4);
        checkOutput("rsvd_err", rate_err_o, 1'b1);
        checkStream("rsvd", 16'b1001, 4, 3);
        applyStimulus(2'b11, 1'b1, 1'b0, 2'b01);
        applyStimulus(2'b11, 1'b0, 1'b1, 2'b01);
        idleCycles(4);
        checkOutput("rsvd_err_sticky", rate_err_o, 1'b1);
        checkStream("after_rsvd", 16'b111, 3, 2);

        $display("[TB] reset while a bit is held");
        applyStimulus(2'b10, 1'b1, 1'b0, 2'b00);
        #2;
        sys_rstn     = 1'b0;
        data_valid_i = 1'b0;
        sym_start    = 1'b0;
        #1;
        checkOutput("arst_valid", data_valid_o, 1'b0);
        checkOutput("arst_ready", data_ready_o, 1'b1);
        checkOutput("arst_out", data_out, 1'b0);
        checkOutput("arst_err", rate_err_o, 1'b0);
        @(posedge sys_clk);
        @(negedge sys_clk);
        #2;
        sys_rstn = 1'b1;
        obs.delete();
        applyStimulus(2'b01, 1'b1, 1'b1, 2'b00);
        idleCycles(4);
        checkStream("post_rst", 16'b01, 2, 1);

        $display("[TB] randomized bursts");
        for (int b = 0; b < 200; b++) begin
            r   = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 8);
            for (int p = 0; p < len; p++) begin
                sos = (p == 0) || ($urandom_range(0, 15) == 0);
                rs  = (p == 0) ? r : 2'($urandom_range(0, 3));
                applyStimulus(2'($urandom_range(0, 3)), sos, p == len - 1, rs);
                if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
            end
        end
        idleCycles(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
